// File: rtl/sfifo_rd_stream.sv
// Read-side adapter: pulls words from sfifo and presents them as a valid/ready stream framed by m_last.
// Optional macro SFIFO_RD_STREAM_BURST_GATE_EN: hold each burst back until the FIFO holds a full burst.
module sfifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH:0]   fifo_count,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [1:0]            buf_level,
   output logic                  fsm_state
);

   // Stream handshake: a beat transfers on a cycle with m_valid & m_ready; once
   // m_valid is high, m_data and m_last hold until that transfer happens.

   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

   typedef enum logic {
      S_WAIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                state;
   logic [CW-1:0]         issue_cnt;
   logic [CW-1:0]         beat_cnt;
   logic                  inflight;
   logic                  pop;
   logic                  gate_ok;
   logic [DATA_WIDTH-1:0] tail;
   logic [2:0]            committed;

   assign m_valid   = (buf_level != 2'd0);
   assign pop       = m_valid & m_ready;
   assign m_last    = m_valid & (beat_cnt == LAST);
   assign fsm_state = (state == S_RUN);

   // Slots already spoken for after this cycle: buffered plus returning, minus leaving.
   assign committed = {1'b0, buf_level} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_r_en = ~fifo_empty & (committed < 3'd2) & gate_ok;

`ifdef SFIFO_RD_STREAM_BURST_GATE_EN
   localparam logic [ADDR_WIDTH:0] BURST_WORDS = (ADDR_WIDTH + 1)'(BURST_LEN);
   assign gate_ok = (state == S_RUN) | (fifo_count >= BURST_WORDS);
`else
   logic unused_count;
   assign unused_count = ^fifo_count;
   assign gate_ok      = 1'b1;
`endif

   // Two-entry skid buffer: m_data is the head register, tail holds the second word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_level <= 2'd0;
         m_data    <= '0;
         tail      <= '0;
         inflight  <= 1'b0;
      end else begin
         inflight <= fifo_r_en;
         case ({inflight, pop})
            2'b10: begin
               if (buf_level == 2'd0) m_data <= fifo_data;
               else                   tail   <= fifo_data;
               buf_level <= buf_level + 2'd1;
            end
            2'b01: begin
               m_data    <= tail;
               buf_level <= buf_level - 2'd1;
            end
            2'b11: begin
               if (buf_level == 2'd1) begin
                  m_data <= fifo_data;
               end else begin
                  m_data <= tail;
                  tail   <= fifo_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Burst tracking: issue side drives the FSM, pop side drives m_last framing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_WAIT;
         issue_cnt <= '0;
         beat_cnt  <= '0;
      end else begin
         if (pop) begin
            beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
         end
         if (fifo_r_en) begin
            if (issue_cnt == LAST) begin
               issue_cnt <= '0;
               state     <= S_WAIT;
            end else begin
               issue_cnt <= issue_cnt + 1'b1;
               state     <= S_RUN;
            end
         end
      end
   end

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Bench for sfifo_rd_stream: behavioural sfifo model, word-order scoreboard and burst framing model.
// Expectations follow SFIFO_RD_STREAM_BURST_GATE_EN when it is defined for the build.
module tb_sfifo_rd_stream;

   localparam int DW = 8;
   localparam int AW = 7;
   localparam int BL = 4;

`ifdef SFIFO_RD_STREAM_BURST_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          fifo_empty = 1'b1;
   logic [AW:0]   fifo_count = '0;
   logic [DW-1:0] fifo_data  = '0;
   logic          fifo_r_en;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [1:0]    buf_level;
   logic          fsm_state;

   logic          wr_en   = 1'b0;
   logic [DW-1:0] wr_data = '0;

   sfifo_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_count (fifo_count),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .buf_level  (buf_level),
      .fsm_state  (fsm_state)
   );

   // Behavioural sfifo: registered read data, flags update after the edge.
   logic [DW-1:0] fifo_q[$];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q.delete();
         fifo_data  <= '0;
         fifo_empty <= 1'b1;
         fifo_count <= '0;
      end else begin
         if (fifo_r_en && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
         if (wr_en) fifo_q.push_back(wr_data);
         fifo_empty <= (fifo_q.size() == 0);
         fifo_count <= (AW + 1)'(fifo_q.size());
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every word written to the FIFO must come out once, in order.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_word;
   int            n_beats, n_reads, run_len, max_run, cyc, last_idx;
   int            beat_cyc[$];
   logic          prev_ren, stalled, held_last;
   logic [DW-1:0] held_data;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         n_beats  = 0;
         n_reads  = 0;
         run_len  = 0;
         prev_ren = 1'b0;
         stalled  = 1'b0;
         last_idx = -1;
      end else begin
         chk("valid_eq_level", m_valid, buf_level != 2'd0);
         chk("level_bound", (int'(buf_level) + int'(prev_ren)) <= 2, 1);
         chk("fsm_state", fsm_state, (n_reads % BL) != 0);
         if ((int'(buf_level) + int'(prev_ren)) == 2 && !(m_valid && m_ready))
            chk("ren_when_full", fifo_r_en, 0);
         if (stalled) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, held_data);
            chk("hold_last", m_last, held_last);
         end
         if (m_valid && m_ready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_word = exp_q.pop_front();
               chk("beat_data", m_data, exp_word);
            end
            chk("beat_last", m_last, (n_beats % BL) == BL - 1);
            if (m_last) last_idx = n_beats;
            beat_cyc.push_back(cyc);
            n_beats++;
         end else if (m_valid) begin
            chk("stall_last", m_last, (n_beats % BL) == BL - 1);
         end
         stalled   = m_valid && !m_ready;
         held_data = m_data;
         held_last = m_last;
         if (fifo_r_en) begin
            n_reads++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         prev_ren = fifo_r_en;
      end
   end

   // ---------------- driver tasks ----------------
   int n_written = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      n_written++;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      m_ready = 1'b0;
      wr_en   = 1'b0;
      rst_n   = 1'b0;
      repeat (2) tick();
      rst_n     = 1'b1;
      n_written = 0;
      tick();
   endtask

   task automatic preload8();
      for (int i = 0; i < 8; i++) write_word(DW'(i));
      repeat (4) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      repeat (3) tick();
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_last", m_last, 0);
      chk("rst_level", buf_level, 0);
      chk("rst_state", fsm_state, 0);
      chk("rst_ren", fifo_r_en, 0);
      rst_n = 1'b1;
      tick();

      // Single word latency: read cycle, capture cycle, then m_valid.
      m_ready = 1'b1;
      write_word(8'h11);
      chk("t1_ren", fifo_r_en, !GATE);
      tick();
      chk("t1_ren_once", fifo_r_en, 0);
      chk("t1_not_yet", m_valid, 0);
      tick();
      chk("t1_valid", m_valid, !GATE);
      chk("t1_data", m_data, GATE ? 8'h00 : 8'h11);
      chk("t1_last", m_last, 0);
      chk("t1_reads", n_reads, GATE ? 0 : 1);
      tick();

      // Preloaded FIFO streams at one beat per clock.
      do_reset();
      preload8();
      beat_cyc.delete();
      m_ready = 1'b1;
      for (int i = 0; i < 40 && n_beats < 8; i++) tick();
      chk("t2_beats", n_beats, 8);
      if (beat_cyc.size() >= 8) chk("t2_rate", beat_cyc[7] - beat_cyc[0], 7);
      chk("t2_last_idx", last_idx, 7);

      // Ready pattern 1,0,0,1: hold checks and ordering run in the monitor.
      do_reset();
      preload8();
      for (int i = 0; i < 60 && n_beats < 8; i++) begin
         m_ready = ((i % 4) == 0) || ((i % 4) == 3);
         tick();
      end
      chk("t3_beats", n_beats, 8);
      chk("t3_drained", exp_q.size(), 0);

      // Reset with a full buffer; framing restarts at beat 0.
      do_reset();
      preload8();
      m_ready = 1'b1;
      repeat (2) tick();
      m_ready = 1'b0;
      for (int i = 0; i < 10 && buf_level != 2'd2; i++) tick();
      chk("t4_full", buf_level, 2);
      rst_n = 1'b0;
      #1;
      chk("t4_valid_drop", m_valid, 0);
      chk("t4_level_clr", buf_level, 0);
      chk("t4_state_clr", fsm_state, 0);
      tick();
      rst_n     = 1'b1;
      n_written = 0;
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) write_word(8'hA0 + DW'(i));
      for (int i = 0; i < 20 && n_beats < 4; i++) tick();
      chk("t4_beats", n_beats, 4);
      chk("t4_last_idx", last_idx, 3);

      // Burst gate: three words wait, the fourth releases a back-to-back burst.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) write_word(8'h50 + DW'(i));
      repeat (6) tick();
      chk("t5_reads_3", n_reads, GATE ? 0 : 3);
      chk("t5_beats_3", n_beats, GATE ? 0 : 3);
      max_run = 0;
      write_word(8'h53);
      repeat (8) tick();
      chk("t5_reads_4", n_reads, 4);
      chk("t5_beats_4", n_beats, 4);
      chk("t5_run", max_run, GATE ? 4 : 1);
      chk("t5_last_idx", last_idx, 3);

      // Random writes and backpressure, padded to whole bursts and drained.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 && fifo_q.size() < 100) write_word(DW'($urandom));
         else tick();
      end
      while ((n_written % BL) != 0) write_word(DW'($urandom));
      m_ready = 1'b1;
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
      chk("t6_drained", exp_q.size(), 0);
      chk("t6_fifo_empty", fifo_empty, 1);
      chk("t6_beats", n_beats, n_written);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
